// File: rtl/camera_tx_pkg.sv
// Shared types and constants for the parallel camera stream transmitter.
package camera_tx_pkg;

    // Frame phases; each non-idle phase spans a whole number of line-times.
    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } tx_state_e;

    // Pixel source select encodings.
    typedef enum logic [1:0] {
        PatExt   = 2'b00,
        PatBars  = 2'b01,
        PatGrad  = 2'b10,
        PatSolid = 2'b11
    } pattern_sel_e;

    localparam logic [15:0] SOLID_COLOUR = 16'hF81F;

    // RGB565 colour of each of the eight vertical bars, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        c = 16'h0000;
        unique case (idx)
            3'd0: c = 16'hFFFF;
            3'd1: c = 16'hFFE0;
            3'd2: c = 16'h07FF;
            3'd3: c = 16'h07E0;
            3'd4: c = 16'hF81F;
            3'd5: c = 16'hF800;
            3'd6: c = 16'h001F;
            3'd7: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_tx_pattern_gen.sv
// Test-pattern source with the same 2-cycle latency as an external BRAM read, so the
// transmitter's capture point does not depend on the selected source.
module cam_tx_pattern_gen
    import camera_tx_pkg::*;
#(
    parameter int ACTIVE_PIX = 320
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [15:0]  i_x,
    input  logic [5:0]   i_y,
    input  pattern_sel_e i_sel,
    input  logic [15:0]  i_pix,
    output logic [15:0]  o_pix
);

    localparam int BAR_W = ACTIVE_PIX / 8;

    logic [15:0]  r_x;
    logic [5:0]   r_y;
    pattern_sel_e r_sel1;
    pattern_sel_e r_sel2;
    logic [15:0]  r_pat;
    logic [2:0]   w_bar;
    logic [15:0]  w_pat;

    // Combinational pattern from the first pipeline stage.
    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_x >= 16'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
        w_pat = 16'h0000;
        case (r_sel1)
            PatBars:  w_pat = bar_colour(w_bar);
            PatGrad:  w_pat = {r_x[4:0], r_y, r_x[4:0]};
            PatSolid: w_pat = SOLID_COLOUR;
            default:  w_pat = 16'h0000;
        endcase
    end

    // Two register stages: coordinates in, then the finished pattern word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x    <= 16'h0000;
            r_y    <= 6'h00;
            r_sel1 <= PatExt;
            r_sel2 <= PatExt;
            r_pat  <= 16'h0000;
        end else begin
            r_x    <= i_x;
            r_y    <= i_y;
            r_sel1 <= i_sel;
            r_sel2 <= r_sel1;
            r_pat  <= w_pat;
        end
    end

    // External data arrives live in the same cycle the pattern word is ready.
    assign o_pix = (r_sel2 == PatExt) ? i_pix : r_pat;

endmodule

// File: rtl/camera_stream_tx.sv
// OV7670-style parallel pixel transmitter: pclk divider, line/frame counters,
// frame FSM, pixel request/capture and byte serialiser.
module camera_stream_tx
    import camera_tx_pkg::*;
#(
    parameter int ACTIVE_PIX   = 320,
    parameter int ACTIVE_LINES = 240,
    parameter int H_BLANK      = 144,
    parameter int VSYNC_LINES  = 3,
    parameter int V_BACK       = 17,
    parameter int V_FRONT      = 10,
    parameter int PCLK_DIV     = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            en_in,
    input  logic [1:0]                      pattern_sel_in,
    input  logic [15:0]                     pix_in,
    output logic                            pix_req_out,
    output logic [$clog2(ACTIVE_PIX)-1:0]   pix_x_out,
    output logic [$clog2(ACTIVE_LINES)-1:0] pix_y_out,
    output logic                            pclk_out,
    output logic                            vsync_out,
    output logic                            href_out,
    output logic [7:0]                      data_out,
    output logic                            frame_start_out
);

    localparam int HALF = PCLK_DIV / 2;
    localparam int DW   = $clog2(PCLK_DIV);
    localparam int XW   = $clog2(ACTIVE_PIX);
    localparam int YW   = $clog2(ACTIVE_LINES);

    localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(HALF);
    // Last cycle before the pclk falling edge; outputs are launched at its end.
    localparam logic [DW-1:0] DIV_FALL = DW'(HALF - 1);
    // Three cycles ahead of the launching edge, leaving two cycles of source latency.
    localparam logic [DW-1:0] DIV_REQ  = DW'((HALF - 1 + PCLK_DIV - 3) % PCLK_DIV);

    localparam logic [15:0] H_LAST   = 16'(2 * ACTIVE_PIX + H_BLANK - 1);
    localparam logic [15:0] H_ACT    = 16'(2 * ACTIVE_PIX);
    localparam logic [15:0] VS_LAST  = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
    localparam logic [15:0] ACT_LAST = 16'(ACTIVE_LINES - 1);
    localparam logic [15:0] VF_LAST  = 16'(V_FRONT - 1);

    tx_state_e    r_state;
    tx_state_e    w_state_next;
    pattern_sel_e r_sel;
    logic [DW-1:0] r_div;
    // r_h/r_v always name the position launched at the next falling edge.
    logic [15:0]  r_h;
    logic [15:0]  r_v;
    logic         r_vsync;
    logic         r_href;
    logic [7:0]   r_data;
    logic         r_frame_start;
    logic [1:0]   r_req_pipe;
    logic [15:0]  r_pix;

    logic         w_tick;
    logic         w_line_end;
    logic [15:0]  w_phase_last;
    logic         w_phase_end;
    logic         w_active_byte;
    logic         w_req;
    logic [15:0]  w_src_pix;

    assign w_tick        = (r_state != StIdle) && (r_div == DIV_FALL);
    assign w_line_end    = (r_h == H_LAST);
    assign w_phase_end   = w_line_end && (r_v == w_phase_last);
    assign w_active_byte = (r_state == StActive) && (r_h < H_ACT);
    assign w_req         = w_active_byte && !r_h[0] && (r_div == DIV_REQ);

    // Number of line-times in the current phase, minus one.
    always_comb begin
        w_phase_last = 16'h0000;
        unique case (r_state)
            StVsync:  w_phase_last = VS_LAST;
            StVback:  w_phase_last = VB_LAST;
            StActive: w_phase_last = ACT_LAST;
            StVfront: w_phase_last = VF_LAST;
            default:  w_phase_last = 16'h0000;
        endcase
    end

    // Next-state logic; phases advance only on a falling-edge tick at phase end.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (en_in) w_state_next = StVsync;
            StVsync:  if (w_tick && w_phase_end) w_state_next = StVback;
            StVback:  if (w_tick && w_phase_end) w_state_next = StActive;
            StActive: if (w_tick && w_phase_end) w_state_next = StVfront;
            StVfront: if (w_tick && w_phase_end) w_state_next = en_in ? StVsync : StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pattern select is frozen for the whole frame at each frame start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel <= PatExt;
        end else if ((r_state != StVsync) && (w_state_next == StVsync)) begin
            r_sel <= pattern_sel_e'(pattern_sel_in);
        end
    end

    // pclk divider and h/v position counters; v counts lines within the current phase.
    always_ff @(posedge clk_in) begin
        if (rst_in || (r_state == StIdle) || (w_state_next == StIdle)) begin
            r_div <= '0;
            r_h   <= 16'h0000;
            r_v   <= 16'h0000;
        end else begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
            if (w_tick) begin
                if (w_line_end) begin
                    r_h <= 16'h0000;
                    r_v <= w_phase_end ? 16'h0000 : r_v + 16'd1;
                end else begin
                    r_h <= r_h + 16'd1;
                end
            end
        end
    end

    // Sync, href and byte bus launched on the pclk falling edge; high byte first.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_vsync       <= 1'b0;
            r_href        <= 1'b0;
            r_data        <= 8'h00;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_vsync       <= (r_state == StVsync);
                r_href        <= w_active_byte;
                r_data        <= w_active_byte ? (r_h[0] ? r_pix[7:0] : r_pix[15:8]) : 8'h00;
                r_frame_start <= (r_state == StVsync) && !r_vsync;
            end
        end
    end

    // Capture the requested pixel two cycles after its request.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_req_pipe <= 2'b00;
            r_pix      <= 16'h0000;
        end else begin
            r_req_pipe <= {r_req_pipe[0], w_req};
            if (r_req_pipe[1]) begin
                r_pix <= w_src_pix;
            end
        end
    end

    cam_tx_pattern_gen #(
        .ACTIVE_PIX (ACTIVE_PIX)
    ) u_pattern_gen (
        .i_clk (clk_in),
        .i_rst (rst_in),
        .i_x   ({1'b0, r_h[15:1]}),
        .i_y   (6'(r_v)),
        .i_sel (r_sel),
        .i_pix (pix_in),
        .o_pix (w_src_pix)
    );

    assign pclk_out        = (r_state != StIdle) && (r_div < DIV_HALF);
    assign vsync_out       = r_vsync;
    assign href_out        = r_href;
    assign data_out        = r_data;
    assign frame_start_out = r_frame_start;
    assign pix_req_out     = w_req;
    assign pix_x_out       = w_req ? r_h[XW:1] : '0;
    assign pix_y_out       = w_req ? r_v[YW-1:0] : '0;

endmodule
